// File: rtl/mcdf_pkg.sv
// Shared channel constants for the multi-channel data formatter.
package mcdf_pkg;
   localparam int CH_DW      = 8;
   localparam int FIFO_DEPTH = 32;
   localparam int MARGIN_W   = $clog2(FIFO_DEPTH) + 1;
endpackage

// File: rtl/chnl_fifo_mem.sv
// Channel FIFO storage: one synchronous write port, one asynchronous read port, no reset.
module chnl_fifo_mem #(
   parameter int DW    = 8,
   parameter int DEPTH = 32
) (
   input  logic                     clk,
   input  logic                     we,
   input  logic [$clog2(DEPTH)-1:0] waddr,
   input  logic [DW-1:0]            wdata,
   input  logic [$clog2(DEPTH)-1:0] raddr,
   output logic [DW-1:0]            rdata
);
   logic [DW-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   assign rdata = mem[raddr];
endmodule

// File: rtl/chnl_slave_fifo.sv
// Slave channel FIFO: show-ahead buffer between a valid/ready channel and the arbiter.
// Defining CHNL_SLV_WORD_CNT_EN adds a 16-bit wrapping count of accepted words (word_cnt).
module chnl_slave_fifo
   import mcdf_pkg::*;
#(
   parameter int DW    = CH_DW,
   parameter int DEPTH = FIFO_DEPTH
) (
   input  logic                   clk,
   input  logic                   rstn,
   input  logic                   en,
   input  logic [DW-1:0]          ch_data,
   input  logic                   ch_valid,
   output logic                   ch_ready,
   output logic                   rcv_vld,
   output logic [DW-1:0]          slv_data,
   output logic                   slv_req,
   input  logic                   slv_fetch,
`ifdef CHNL_SLV_WORD_CNT_EN
   output logic [15:0]            word_cnt,
`endif
   output logic [$clog2(DEPTH):0] slv_margin
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [CW-1:0] count;
   logic          push;
   logic          pop;

   // rstn gates ready so the channel sees no acceptance while reset is held
   assign ch_ready   = rstn & en & (count < DEPTH_C);
   assign push       = ch_valid & ch_ready;
   assign rcv_vld    = push;
   assign slv_req    = (count != '0);
   assign pop        = slv_fetch & slv_req;
   assign slv_margin = DEPTH_C - count;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

`ifdef CHNL_SLV_WORD_CNT_EN
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn)     word_cnt <= '0;
      else if (push) word_cnt <= word_cnt + 16'd1;
   end
`endif

   chnl_fifo_mem #(
      .DW    (DW),
      .DEPTH (DEPTH)
   ) u_mem (
      .clk   (clk),
      .we    (push),
      .waddr (wr_ptr),
      .wdata (ch_data),
      .raddr (rd_ptr),
      .rdata (slv_data)
   );
endmodule

// File: doc/chnl_slave_fifo.md
CHNL_SLAVE_FIFO -- requirements
Module: chnl_slave_fifo

Interface
REQ-001 SHALL have parameter DW, default 8, channel data width.
REQ-002 SHALL have parameter DEPTH, default 32, buffer depth in words (power of two).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rstn  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port en  input  1  channel enable from register block.
REQ-006 SHALL have port ch_data  input  DW  channel write data.
REQ-007 SHALL have port ch_valid  input  1  upstream data valid.
REQ-008 SHALL have port ch_ready  output  1  upstream may transfer this cycle.
REQ-009 SHALL have port rcv_vld  output  1  a word was accepted this cycle.
REQ-010 SHALL have port slv_data  output  DW  head-of-buffer word.
REQ-011 SHALL have port slv_req  output  1  buffer non-empty, requests arbiter service.
REQ-012 SHALL have port slv_fetch  input  1  arbiter pops the head word.
REQ-013 SHALL have port slv_margin  output  $clog2(DEPTH)+1  free word slots.

Function
REQ-014 SHALL compute ch_ready = en AND (count < DEPTH), combinationally from registered count.
REQ-015 SHALL define push = ch_valid AND ch_ready, and drive rcv_vld = push in the same cycle.
REQ-016 SHALL write ch_data to mem[wr_ptr] on push and advance wr_ptr modulo DEPTH (DEPTH-1 wraps to 0).
REQ-017 SHALL define pop = slv_fetch AND slv_req; slv_fetch while empty SHALL be ignored, with no pointer or count change.
REQ-018 SHALL present slv_data = mem[rd_ptr] show-ahead (no read latency); pop advances rd_ptr modulo DEPTH.
REQ-019 SHALL provide no fall-through: a word pushed in cycle N becomes visible on slv_data/slv_req at cycle N+1.
REQ-020 SHALL update count by +1 on push only, -1 on pop only, and leave it unchanged on simultaneous push and pop.
REQ-021 SHALL drive slv_req = (count != 0) and slv_margin = DEPTH - count.
REQ-022 SHALL not push when full, even with a simultaneous pop; ch_ready rises the cycle after the pop.
REQ-023 SHALL drop ch_ready in the same cycle en falls; buffered words SHALL remain poppable while en = 0.
REQ-024 SHALL keep ch_data/ch_valid stall-safe: upstream holds data while ch_ready = 0, and no word is lost or duplicated.

Reset
REQ-025 SHALL clear wr_ptr, rd_ptr and count to 0 while rstn = 0, regardless of clk.
REQ-026 SHALL hold these values during reset: ch_ready = 0, rcv_vld = 0, slv_req = 0, slv_margin = DEPTH, slv_data = don't-care.
REQ-027 SHALL discard buffered contents on reset mid-operation; memory array needs no reset.

Configuration
REQ-028 SHALL, with CHNL_SLV_WORD_CNT_EN defined, add output word_cnt (16 bits, reset 0), incremented on every push and wrapping 0xFFFF -> 0x0000.
REQ-029 SHALL, without CHNL_SLV_WORD_CNT_EN, omit port word_cnt and its logic entirely; all other behaviour SHALL be identical.

Structure
REQ-030 SHALL take CH_DW, FIFO_DEPTH and MARGIN_W constants from shared package mcdf_pkg.
REQ-031 SHALL isolate the storage array in sub-module chnl_fifo_mem (1 write port, 1 async read port); pointer, count and handshake logic SHALL stay in chnl_slave_fifo.

Verification
REQ-032 SHALL cover: en=1, push 0xA5 at cycle N -> rcv_vld=1 at N; slv_req=1, slv_data=0xA5, slv_margin=31 at N+1.
REQ-033 SHALL cover: 32 pushes with no fetch -> ch_ready=0 and slv_margin=0 after the 32nd; a 33rd ch_valid is not accepted; one fetch -> ch_ready=1 the next cycle.
REQ-034 SHALL cover: simultaneous push and fetch at count=5 -> count stays 5 and the popped word is the oldest.
REQ-035 SHALL cover: 40 push/pop pairs -> pointers wrap past 31 and output order equals input order.
REQ-036 SHALL cover: en deasserted with 3 words buffered -> ch_ready=0 immediately and 3 fetches drain 3 words; fetch while empty -> no change.
REQ-037 SHALL cover: rstn pulsed low with 10 words buffered -> slv_req=0 and slv_margin=32 asynchronously; word_cnt=0 if CHNL_SLV_WORD_CNT_EN is defined.
